// File: rtl/parking_alert_pkg.sv
// rtl/parking_alert_pkg.sv - shared types, defaults and helpers for parking_alert_gen
package parking_alert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 26;
  localparam int DEF_PULSE_W = 4;

  // a single channel still needs a one-bit index
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alert_channel.sv
// rtl/alert_channel.sv - one burst blink channel: edge detect, IDLE/HIGH/LOW FSM, counters
// ALERT_RETRIGGER_EN: a rising edge mid-burst restarts the burst with freshly latched settings
module alert_channel
  import parking_alert_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  input  logic               abort,
  input  logic [CNT_W-1:0]   period,
  input  logic [PULSE_W-1:0] pulses,
  output logic               ch_out,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   per_q, per_d, cnt_q, cnt_d, half_last;
  logic [PULSE_W-1:0] pul_q, pul_d, pcnt_q, pcnt_d;
  logic               trig_q, rise, retrig, load, done_d;

  assign rise = trig & ~trig_q;
  // a latched period of 0 behaves as a one-cycle half-period
  assign half_last = (per_q == '0) ? '0 : per_q - CNT_W'(1);

`ifdef ALERT_RETRIGGER_EN
  assign retrig = rise;
`else
  assign retrig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    pul_d   = pul_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: load = rise && (pulses != '0);
        default: begin
          if (retrig) begin
            if (pulses != '0) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              pcnt_d  = '0;
            end
          end else if (cnt_q != half_last) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            if (state_q == HIGH) begin
              state_d = LOW;
            end else if (pcnt_q == pul_q - PULSE_W'(1)) begin
              state_d = IDLE;
              pcnt_d  = '0;
              done_d  = 1'b1;
            end else begin
              pcnt_d  = pcnt_q + PULSE_W'(1);
              state_d = HIGH;
            end
          end
        end
      endcase
    end
    if (load) begin
      per_d   = period;
      pul_d   = pulses;
      cnt_d   = '0;
      pcnt_d  = '0;
      state_d = HIGH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      pul_q   <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b1;
      ch_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      pul_q   <= pul_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig;
      ch_out  <= (state_d == HIGH);
      busy    <= (state_d != IDLE);
      done    <= done_d;
    end
  end

endmodule

// File: rtl/parking_alert_gen.sv
// rtl/parking_alert_gen.sv - multi-channel burst blink generator with fixed-priority shared output
// ALERT_RETRIGGER_EN (see alert_channel) enables mid-burst retrigger on every channel
module parking_alert_gen
  import parking_alert_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int PULSE_W = DEF_PULSE_W,
  localparam int ID_W    = id_width(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         trig,
  input  logic [NUM_CH-1:0]         abort,
  input  logic [NUM_CH*CNT_W-1:0]   period,
  input  logic [NUM_CH*PULSE_W-1:0] pulses,
  output logic [NUM_CH-1:0]         ch_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic                      alert_out,
  output logic [ID_W-1:0]           active_id
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    alert_channel #(
      .CNT_W  (CNT_W),
      .PULSE_W(PULSE_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (trig[g]),
      .abort (abort[g]),
      .period(period[g*CNT_W +: CNT_W]),
      .pulses(pulses[g*PULSE_W +: PULSE_W]),
      .ch_out(ch_out[g]),
      .busy  (busy[g]),
      .done  (done[g])
    );
  end

  // scan from the top down so the lowest busy index is the last to win
  always_comb begin
    alert_out = 1'b0;
    active_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (busy[i]) begin
        alert_out = ch_out[i];
        active_id = ID_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_parking_alert_gen.sv
// tb/tb_parking_alert_gen.sv - self-checking bench for parking_alert_gen (NUM_CH=2, CNT_W=8, PULSE_W=3)
module tb_parking_alert_gen;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int PULSE_W = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         trig, abort;
  logic [NUM_CH*CNT_W-1:0]   period;
  logic [NUM_CH*PULSE_W-1:0] pulses;
  logic [NUM_CH-1:0]         ch_out, busy, done;
  logic                      alert_out;
  logic [0:0]                active_id;

  always #5 clk = ~clk;

  parking_alert_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .period(period), .pulses(pulses),
    .ch_out(ch_out), .busy(busy), .done(done), .alert_out(alert_out), .active_id(active_id)
  );

  typedef struct {
    logic [1:0] ch_out;
    logic [1:0] busy;
    logic [1:0] done;
    logic       alert;
    logic [0:0] id;
  } exp_t;

  typedef struct {
    int ch; int per; int pul; int exp_busy; int exp_high; int exp_done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0, failures = 0;

  // reference model: each burst is described by its start cycle and P/N
  logic [1:0] m_tq;
  bit         m_act[2];
  int         m_start[2], m_p[2], m_n[2];
  int         m_cyc;
  int         cnt_busy[2], cnt_high[2], cnt_done[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ch_out"}, 32'(ch_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_alert"}, 32'(alert_out), 0);
    chk({tag, "_id"}, 32'(active_id), 0);
  endtask

  function automatic bit m_busy(input int i, input int k);
    return m_act[i] && ((k - m_start[i]) < 2 * m_n[i] * m_p[i]);
  endfunction

  task automatic model_reset();
    m_tq  = '1;
    m_cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_start[i] = 0; m_p[i] = 1; m_n[i] = 0;
    end
    sb.delete();
  endtask

  task automatic model_step();
    exp_t x;
    int   pul, per, e;
    bit   rise, bsy;
    for (int i = 0; i < 2; i++) begin
      rise = trig[i] & ~m_tq[i];
      bsy  = m_busy(i, m_cyc);
      pul  = int'(pulses[i*PULSE_W +: PULSE_W]);
      per  = int'(period[i*CNT_W +: CNT_W]);
      if (abort[i]) begin
        m_act[i] = 0;
      end else if (rise && !bsy) begin
        if (pul != 0) begin
          m_act[i] = 1; m_start[i] = m_cyc + 1; m_n[i] = pul; m_p[i] = (per == 0) ? 1 : per;
        end
`ifdef ALERT_RETRIGGER_EN
      end else if (rise && bsy) begin
        if (pul != 0) begin
          m_act[i] = 1; m_start[i] = m_cyc + 1; m_n[i] = pul; m_p[i] = (per == 0) ? 1 : per;
        end else begin
          m_act[i] = 0;
        end
`endif
      end
    end
    m_tq = trig;
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      e = m_cyc - m_start[i];
      x.busy[i]   = m_busy(i, m_cyc);
      x.ch_out[i] = x.busy[i] && ((e % (2 * m_p[i])) < m_p[i]);
      x.done[i]   = m_act[i] && (e == 2 * m_n[i] * m_p[i]);
    end
    x.alert = 1'b0;
    x.id    = 1'b0;
    if (x.busy[1]) begin x.alert = x.ch_out[1]; x.id = 1'b1; end
    if (x.busy[0]) begin x.alert = x.ch_out[0]; x.id = 1'b0; end
    sb.push_back(x);
  endtask

  // commit the inputs currently driven, advance one cycle, check the resulting outputs
  task automatic tick();
    exp_t x;
    model_step();
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty actual=0 expected=1");
    end else begin
      x = sb.pop_front();
      chk($sformatf("ch_out@%0d", m_cyc), 32'(ch_out), 32'(x.ch_out));
      chk($sformatf("busy@%0d", m_cyc), 32'(busy), 32'(x.busy));
      chk($sformatf("done@%0d", m_cyc), 32'(done), 32'(x.done));
      chk($sformatf("alert_out@%0d", m_cyc), 32'(alert_out), 32'(x.alert));
      chk($sformatf("active_id@%0d", m_cyc), 32'(active_id), 32'(x.id));
    end
    for (int i = 0; i < 2; i++) begin
      cnt_busy[i] += int'(busy[i]);
      cnt_high[i] += int'(ch_out[i]);
      cnt_done[i] += int'(done[i]);
    end
  endtask

  task automatic fire(input int ch, input int per, input int pul);
    period[ch*CNT_W +: CNT_W]     = CNT_W'(per);
    pulses[ch*PULSE_W +: PULSE_W] = PULSE_W'(pul);
    trig[ch] = 1'b1;
    tick();
    trig[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{0, 3,   2, 12,  6,   1};
    vecs[1] = '{0, 0,   1, 2,   1,   1};
    vecs[2] = '{1, 5,   1, 10,  5,   1};
    vecs[3] = '{0, 1,   7, 14,  7,   1};
    vecs[4] = '{1, 0,   0, 0,   0,   0};
    vecs[5] = '{0, 255, 1, 510, 255, 1};
    vecs[6] = '{1, 2,   3, 12,  6,   1};
    vecs[7] = '{1, 1,   7, 14,  7,   1};

    rst_n = 1'b0; trig = '0; abort = '0; period = '0; pulses = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    model_reset();
    repeat (2) tick();

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 2; i++) begin cnt_busy[i] = 0; cnt_high[i] = 0; cnt_done[i] = 0; end
      fire(vecs[v].ch, vecs[v].per, vecs[v].pul);
      repeat (2 * vecs[v].pul * ((vecs[v].per == 0) ? 1 : vecs[v].per) + 4) tick();
      chk($sformatf("vec%0d_busy_cycles", v), cnt_busy[vecs[v].ch], vecs[v].exp_busy);
      chk($sformatf("vec%0d_high_cycles", v), cnt_high[vecs[v].ch], vecs[v].exp_high);
      chk($sformatf("vec%0d_done_count", v), cnt_done[vecs[v].ch], vecs[v].exp_done);
    end

    // basic burst latency, then a new edge accepted in the done cycle
    fire(0, 3, 2);
    n = 1;
    while (!done[0] && n < 40) begin tick(); n++; end
    chk("basic_done_latency", n, 13);
    chk("basic_busy_in_done", 32'(busy[0]), 0);
    fire(0, 1, 1);
    chk("done_cycle_retrigger_busy", 32'(busy[0]), 1);
    repeat (4) tick();

    // priority: ch0 preempts a running ch1 burst
    fire(1, 4, 3);
    n = 1;
    repeat (4) begin tick(); n++; end
    fire(0, 2, 1);
    n++;
    chk("prio_active_id", 32'(active_id), 0);
    chk("prio_alert", 32'(alert_out), 1);
    while (!done[1] && n < 60) begin tick(); n++; end
    chk("prio_ch1_done_latency", n, 25);
    repeat (3) tick();

    // abort on the second HIGH cycle, then abort together with an edge
    fire(0, 3, 2);
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_ch_out", 32'(ch_out[0]), 0);
    n = 0;
    repeat (15) begin tick(); n += int'(done[0]); end
    chk("abort_no_done", n, 0);
    trig[0] = 1'b1; abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    repeat (2) tick();
    chk("abort_edge_consumed", 32'(busy[0]), 0);
    trig[0] = 1'b0;
    repeat (2) tick();

    // edge during the first LOW phase with a new period
    fire(0, 3, 2);
    n = 1;
    repeat (4) begin tick(); n++; end
    period[7:0] = 8'd2;
    trig[0] = 1'b1;
    tick();
    n++;
    trig[0] = 1'b0;
`ifdef ALERT_RETRIGGER_EN
    chk("retrig_ch_out", 32'(ch_out[0]), 1);
`else
    chk("retrig_ch_out", 32'(ch_out[0]), 0);
`endif
    while (!done[0] && n < 40) begin tick(); n++; end
`ifdef ALERT_RETRIGGER_EN
    chk("retrig_done_latency", n, 14);
`else
    chk("retrig_done_latency", n, 13);
`endif
    repeat (3) tick();

    // asynchronous reset mid-HIGH, trig held through release, then a clean edge
    fire(0, 3, 2);
    tick();
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    trig[0] = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("held_trig_no_burst", 32'(busy[0]), 0);
    trig[0] = 1'b0;
    tick();
    fire(0, 2, 1);
    chk("post_reset_burst_busy", 32'(busy[0]), 1);
    chk("post_reset_burst_out", 32'(ch_out[0]), 1);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
